gpu_cmd_queue: RTL and testbench

Buffers raster commands from the CPU and sequences them into the GPU's single-command execute/busy interface. Sits between the CPU core and the raster GPU in vgacpu, and drives the gpu_* port group. It guarantees gpu_execute_request is a one-cycle pulse that is never raised while the GPU is busy. It also holds command operands stable for the whole execution.

---
 rtl/gpu_cmd_queue.sv | 209 ++++++++++++++++++++
 tb/tb_gpu_cmd_queue.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_cmd_queue.sv
// Raster command queue between the CPU core and the raster GPU.
// Buffers commands in a small circular FIFO and issues them one at a time
// over the GPU's execute/busy handshake. Operands are held stable for the
// whole execution, and the execute pulse is never raised while busy is high.

package gpu_cmd_queue_pkg;

    typedef enum logic [2:0] {
        RASTER_CMD_FILL   = 3'd0,
        RASTER_CMD_POINT  = 3'd1,
        RASTER_CMD_LINE   = 3'd2,
        RASTER_CMD_RECT   = 3'd3,
        RASTER_CMD_CIRCLE = 3'd4
    } raster_command_t;

endpackage

module gpu_cmd_queue
    import gpu_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_sync,

    input  logic            push,
    input  raster_command_t push_command,
    input  logic [7:0]      push_x0,
    input  logic [7:0]      push_y0,
    input  logic [7:0]      push_x1,
    input  logic [7:0]      push_y1,
    input  logic [2:0]      push_colour,

    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count,
    output logic            overflow,
    output logic            idle,

    output raster_command_t gpu_command,
    output logic [7:0]      gpu_x0,
    output logic [7:0]      gpu_y0,
    output logic [7:0]      gpu_x1,
    output logic [7:0]      gpu_y1,
    output logic [2:0]      gpu_colour,
    output logic            gpu_execute_request,
    input  logic            gpu_busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        raster_command_t cmd;
        logic [7:0]      x0;
        logic [7:0]      y0;
        logic [7:0]      x1;
        logic [7:0]      y1;
        logic [2:0]      colour;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SETTLE = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam entry_t RESET_ENTRY = '{
        cmd:    RASTER_CMD_FILL,
        x0:     8'd0,
        y0:     8'd0,
        x1:     8'd0,
        y1:     8'd0,
        colour: 3'd0
    };

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic            overflow_q, overflow_d;
    logic            exec_q, exec_d;
    entry_t          out_q, out_d;

    entry_t          mem [DEPTH];

    logic            queueEmpty;
    logic            queueFull;
    logic            doPop;
    logic            pushAccept;
    entry_t          pushEntry;
    entry_t          headEntry;

    assign queueEmpty = (count_q == '0);
    assign queueFull  = (count_q == CW'(DEPTH));

    // A pop only happens on the cycle the issue FSM leaves IDLE.
    assign doPop      = (state_q == IDLE) && !queueEmpty && !gpu_busy;

    // A full queue still takes a push when the head leaves on the same edge.
    assign pushAccept = push && (!queueFull || doPop);

    assign pushEntry = '{
        cmd:    push_command,
        x0:     push_x0,
        y0:     push_y0,
        x1:     push_x1,
        y1:     push_y1,
        colour: push_colour
    };

    assign headEntry = mem[rdPtr_q];

    // Issue sequencer: latch the head entry, pulse execute, then wait for busy to fall.
    always_comb begin
        state_d = state_q;
        exec_d  = 1'b0;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (doPop) begin
                    out_d   = headEntry;
                    exec_d  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!gpu_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Queue bookkeeping: pointers, occupancy and the sticky drop flag.
    always_comb begin
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pushAccept) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        if (pushAccept && !doPop) begin
            count_d = count_q + CW'(1);
        end else if (doPop && !pushAccept) begin
            count_d = count_q - CW'(1);
        end
        if (push && !pushAccept) begin
            overflow_d = 1'b1;
        end
    end

    // State, control and registered GPU operands.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            overflow_q <= 1'b0;
            exec_q     <= 1'b0;
            out_q      <= RESET_ENTRY;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            overflow_q <= overflow_d;
            exec_q     <= exec_d;
            out_q      <= out_d;
        end
    end

    // Queue storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (pushAccept) begin
            mem[wrPtr_q] <= pushEntry;
        end
    end

    assign full                = queueFull;
    assign empty               = queueEmpty;
    assign count               = count_q;
    assign overflow            = overflow_q;
    assign idle                = queueEmpty && (state_q == IDLE) && !gpu_busy;

    assign gpu_command         = out_q.cmd;
    assign gpu_x0              = out_q.x0;
    assign gpu_y0              = out_q.y0;
    assign gpu_x1              = out_q.x1;
    assign gpu_y1              = out_q.y1;
    assign gpu_colour          = out_q.colour;
    assign gpu_execute_request = exec_q;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Self-checking bench for gpu_cmd_queue: a table of push vectors feeds a
// scoreboard of expected issues, and a negedge monitor compares every
// execute pulse and checks that operands hold between issues.
`timescale 1ns/1ps

module tb_gpu_cmd_queue;
    import gpu_cmd_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        raster_command_t cmd;
        logic [7:0]      x0;
        logic [7:0]      y0;
        logic [7:0]      x1;
        logic [7:0]      y1;
        logic [2:0]      colour;
        bit              expAccept;
        int              expCount;
    } vec_t;

    logic            clk;
    logic            rst_sync;
    logic            push;
    raster_command_t push_command;
    logic [7:0]      push_x0, push_y0, push_x1, push_y1;
    logic [2:0]      push_colour;
    logic            full, empty, overflow, idle;
    logic [CW-1:0]   count;
    raster_command_t gpu_command;
    logic [7:0]      gpu_x0, gpu_y0, gpu_x1, gpu_y1;
    logic [2:0]      gpu_colour;
    logic            gpu_execute_request;
    logic            gpu_busy;

    int              assertions = 0;
    int              failures   = 0;

    vec_t            vecs [21];
    vec_t            sb [$];

    int              busyLen  = 0;
    bit              holdBusy = 0;
    int              busyRem  = 0;

    bit              checking     = 0;
    bit              prevExec     = 0;
    bit              haveLast     = 0;
    int              cyc          = 0;
    int              lastIssueCyc = 0;
    int              minSpacing   = 0;
    int              spacingExact = 0;
    logic [37:0]     lastIssued   = '0;

    gpu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_sync            (rst_sync),
        .push                (push),
        .push_command        (push_command),
        .push_x0             (push_x0),
        .push_y0             (push_y0),
        .push_x1             (push_x1),
        .push_y1             (push_y1),
        .push_colour         (push_colour),
        .full                (full),
        .empty               (empty),
        .count               (count),
        .overflow            (overflow),
        .idle                (idle),
        .gpu_command         (gpu_command),
        .gpu_x0              (gpu_x0),
        .gpu_y0              (gpu_y0),
        .gpu_x1              (gpu_x1),
        .gpu_y1              (gpu_y1),
        .gpu_colour          (gpu_colour),
        .gpu_execute_request (gpu_execute_request),
        .gpu_busy            (gpu_busy)
    );

    // 100 MHz bench clock; the DUT only cares about edges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GPU model: busy rises the cycle after a request and lasts busyLen cycles.
    always @(posedge clk) begin
        if (gpu_execute_request) begin
            busyRem <= busyLen;
        end else if (busyRem > 0) begin
            busyRem <= busyRem - 1;
        end
    end
    assign gpu_busy = holdBusy || (busyRem != 0);

    function automatic logic [37:0] packVec(input vec_t v);
        return {v.cmd, v.x0, v.y0, v.x1, v.y1, v.colour};
    endfunction

    function automatic logic [37:0] packOut();
        return {gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour};
    endfunction

    function automatic vec_t mk(input raster_command_t c, input int a, input int b,
                                input int d, input int e, input int col,
                                input bit acc, input int cnt);
        vec_t v;
        v.cmd       = c;
        v.x0        = 8'(a);
        v.y0        = 8'(b);
        v.x1        = 8'(d);
        v.y1        = 8'(e);
        v.colour    = 3'(col);
        v.expAccept = acc;
        v.expCount  = cnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    // Issue monitor: scoreboard compare on each pulse, operand hold otherwise.
    always @(negedge clk) begin
        cyc++;
        if (checking) begin
            checkOutput("noDoublePulse", 64'(prevExec & gpu_execute_request), 64'd0);
            if (gpu_execute_request) begin
                if (sb.size() == 0) begin
                    assertions++;
                    failures++;
                    $display("[TB] FAIL unexpectedIssue: got issue of 0x%0h, expected no pending command",
                             packOut());
                end else begin
                    checkOutput("issueOrder", 64'(packOut()), 64'(packVec(sb.pop_front())));
                end
                if (haveLast && spacingExact > 0) begin
                    checkOutput("spacingExact", 64'(cyc - lastIssueCyc), 64'(spacingExact));
                end else if (haveLast && minSpacing > 0) begin
                    checkOutput("spacingMin", 64'((cyc - lastIssueCyc) >= minSpacing), 64'd1);
                end
                haveLast     = 1;
                lastIssueCyc = cyc;
                lastIssued   = packOut();
            end else begin
                checkOutput("operandHold", 64'(packOut()), 64'(lastIssued));
            end
        end
        prevExec = gpu_execute_request;
    end

    task automatic resetDut();
        push     = 1'b0;
        rst_sync = 1'b1;
        @(posedge clk);
        #1;
        rst_sync   = 1'b0;
        lastIssued = '0;
        checking   = 1;
    endtask

    task automatic applyStimulus(input vec_t v, input bit releaseBusy);
        push_command = v.cmd;
        push_x0      = v.x0;
        push_y0      = v.y0;
        push_x1      = v.x1;
        push_y1      = v.y1;
        push_colour  = v.colour;
        push         = 1'b1;
        if (releaseBusy) holdBusy = 0;
        if (v.expAccept) sb.push_back(v);
        @(posedge clk);
        #1;
        push = 1'b0;
        checkOutput("countAfterPush", 64'(count), 64'(v.expCount));
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (idle && sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drainIdle", 64'(idle), 64'd1);
        checkOutput("drainPending", 64'(sb.size()), 64'd0);
        checkOutput("drainEmpty", 64'(empty), 64'd1);
    endtask

    // Watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = mk(RASTER_CMD_LINE,   10,  10, 100, 100, 6, 1, 1);
        vecs[1]  = mk(RASTER_CMD_RECT,    1,   2,   3,   4, 1, 1, 1);
        vecs[2]  = mk(RASTER_CMD_LINE,   20,  30,  40,  50, 2, 1, 1);
        vecs[3]  = mk(RASTER_CMD_CIRCLE, 60,  70,  80,  90, 3, 1, 2);
        vecs[4]  = mk(RASTER_CMD_POINT,  11,  12,  13,  14, 4, 1, 1);
        vecs[5]  = mk(RASTER_CMD_LINE,   21,  22,  23,  24, 5, 1, 2);
        vecs[6]  = mk(RASTER_CMD_RECT,   31,  32,  33,  34, 6, 1, 3);
        vecs[7]  = mk(RASTER_CMD_FILL,   41,  42,  43,  44, 7, 1, 4);
        vecs[8]  = mk(RASTER_CMD_CIRCLE, 51,  52,  53,  54, 1, 0, 4);
        vecs[9]  = mk(RASTER_CMD_LINE,  101, 102, 103, 104, 1, 1, 1);
        vecs[10] = mk(RASTER_CMD_RECT,  111, 112, 113, 114, 2, 1, 2);
        vecs[11] = mk(RASTER_CMD_POINT, 121, 122, 123, 124, 3, 1, 3);
        vecs[12] = mk(RASTER_CMD_LINE,  131, 132, 133, 134, 4, 1, 4);
        vecs[13] = mk(RASTER_CMD_CIRCLE,200, 201, 202, 203, 5, 1, 4);
        vecs[14] = mk(RASTER_CMD_POINT,   5,   6,   0,   0, 1, 1, 1);
        vecs[15] = mk(RASTER_CMD_POINT,   7,   8,   0,   0, 2, 1, 1);
        vecs[16] = mk(RASTER_CMD_POINT, 255, 254,   0,   0, 7, 1, 2);
        vecs[17] = mk(RASTER_CMD_LINE,   90,  91,  92,  93, 1, 1, 1);
        vecs[18] = mk(RASTER_CMD_RECT,   94,  95,  96,  97, 2, 1, 1);
        vecs[19] = mk(RASTER_CMD_FILL,   98,  99, 100, 101, 3, 1, 2);
        vecs[20] = mk(RASTER_CMD_POINT, 170, 171, 172, 173, 6, 1, 1);

        rst_sync     = 1'b0;
        push         = 1'b0;
        push_command = RASTER_CMD_FILL;
        push_x0      = '0;
        push_y0      = '0;
        push_x1      = '0;
        push_y1      = '0;
        push_colour  = '0;
        repeat (2) @(posedge clk);

        // Reset state and a single command with an idle GPU.
        resetDut();
        checkOutput("rstCount", 64'(count), 64'd0);
        checkOutput("rstEmpty", 64'(empty), 64'd1);
        checkOutput("rstFull", 64'(full), 64'd0);
        checkOutput("rstOverflow", 64'(overflow), 64'd0);
        checkOutput("rstExec", 64'(gpu_execute_request), 64'd0);
        checkOutput("rstOperands", 64'(packOut()), 64'd0);
        checkOutput("rstIdle", 64'(idle), 64'd1);
        busyLen = 0;
        applyStimulus(vecs[0], 0);
        checkOutput("t1ExecEarly", 64'(gpu_execute_request), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("t1ExecLatency", 64'(gpu_execute_request), 64'd1);
        checkOutput("t1CountPopped", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("t1ExecOneCycle", 64'(gpu_execute_request), 64'd0);
        checkOutput("t1X1Held", 64'(gpu_x1), 64'd100);
        waitIdle(50);

        // Three back-to-back commands against a 20-cycle busy GPU.
        busyLen    = 20;
        haveLast   = 0;
        minSpacing = 22;
        for (int i = 1; i <= 3; i++) applyStimulus(vecs[i], 0);
        waitIdle(200);
        minSpacing = 0;

        // Fill while busy, drop the fifth push, then drain in order.
        busyLen  = 3;
        holdBusy = 1;
        for (int i = 4; i <= 7; i++) applyStimulus(vecs[i], 0);
        checkOutput("t3FullAt4", 64'(full), 64'd1);
        checkOutput("t3NoOverflowYet", 64'(overflow), 64'd0);
        applyStimulus(vecs[8], 0);
        checkOutput("t3Overflow", 64'(overflow), 64'd1);
        checkOutput("t3NoIssueWhileBusy", 64'(gpu_execute_request), 64'd0);
        holdBusy = 0;
        waitIdle(200);
        checkOutput("t3OverflowSticky", 64'(overflow), 64'd1);

        // Full queue with a push on the same edge as a pop.
        resetDut();
        busyLen  = 2;
        holdBusy = 1;
        for (int i = 9; i <= 12; i++) applyStimulus(vecs[i], 0);
        checkOutput("t4Full", 64'(full), 64'd1);
        applyStimulus(vecs[13], 1);
        checkOutput("t4NoOverflow", 64'(overflow), 64'd0);
        checkOutput("t4Issue", 64'(gpu_execute_request), 64'd1);
        waitIdle(200);

        // GPU that never raises busy: issues exactly four cycles apart.
        busyLen      = 0;
        haveLast     = 0;
        spacingExact = 4;
        for (int i = 14; i <= 16; i++) applyStimulus(vecs[i], 0);
        waitIdle(100);
        spacingExact = 0;

        // Reset during WAIT with commands queued and the GPU still busy.
        busyLen = 30;
        for (int i = 17; i <= 19; i++) applyStimulus(vecs[i], 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t6CountBefore", 64'(count), 64'd2);
        checkOutput("t6BusyBefore", 64'(gpu_busy), 64'd1);
        sb.delete();
        resetDut();
        checkOutput("t6RstCount", 64'(count), 64'd0);
        checkOutput("t6RstExec", 64'(gpu_execute_request), 64'd0);
        checkOutput("t6RstOperands", 64'(packOut()), 64'd0);
        checkOutput("t6RstIdle", 64'(idle), 64'd0);
        applyStimulus(vecs[20], 0);
        for (int i = 0; i < 100 && gpu_busy; i++) begin
            checkOutput("t6HoldWhileBusy", 64'(gpu_execute_request), 64'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("t6BusyFell", 64'(gpu_busy), 64'd0);
        waitIdle(50);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
